// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Round-robin arbiter that time-shares one external W-bit adder
//            among NREQ requesters. The granted operand pair and carry-in are
//            muxed onto the adder. The adder result is captured in a response
//            register and returned with the requester index.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/req_ready        - per-requester handshake
//            req_x/req_y/req_cin        - packed operands, requester i at [i*W +: W]
//            add_x/add_y/add_cin        - drive to the shared adder (zero when idle)
//            add_s/add_cout             - result from the shared adder
//            rsp_valid/rsp_ready        - response handshake
//            rsp_id/rsp_sum/rsp_cout    - registered response payload
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 6,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_cin,
  input  logic [W-1:0]      add_s,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_rsp_id;
  logic [W-1:0]   r_rsp_sum;
  logic           r_rsp_cout;

  logic           w_can_accept;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_ptr_nxt;

  // Requester index reached by stepping k places up from base, with wrap.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant selection, adder drive and next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_found     = 1'b0;
    w_gnt_id    = '0;
    req_ready   = '0;
    add_x       = '0;
    add_y       = '0;
    add_cin     = 1'b0;

    // rst_n gates the grant so the handshake and adder drive are silent
    // for the whole time reset is held, not only after the first edge.
    w_can_accept = rst_n && ((r_state == S_IDLE) || rsp_ready);

    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_idx(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_gnt_id = wrap_idx(r_ptr, k);
      end
    end

    w_grant = w_can_accept && w_found;

    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (w_gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_x        = req_x[i*W +: W];
        add_y        = req_y[i*W +: W];
        add_cin      = req_cin[i];
      end
    end

    // A new grant always lands in RESP; that covers the back-to-back case
    // where the held response is consumed in the same cycle.
    if (w_grant) begin
      w_state_nxt = S_RESP;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : (w_gnt_id + IDW'(1));

  // --------------------------------------------------------------------------
  // Response capture and round-robin pointer; both move only on accept
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_rsp_id   <= '0;
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
    end else if (w_grant) begin
      r_ptr      <= w_ptr_nxt;
      r_rsp_id   <= w_gnt_id;
      r_rsp_sum  <= add_s;
      r_rsp_cout <= add_cout;
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arbiter
// Purpose  : Self-checking bench for adder_share_arbiter. Models the shared
//            adder, keeps a behavioural reference of the arbiter and compares
//            every output on each falling edge, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_cin;
  logic [W-1:0]      add_x;
  logic [W-1:0]      add_y;
  logic              add_cin;
  logic [W-1:0]      add_s;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  int total = 0;
  int bad   = 0;

  adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_cin  (req_cin),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout)
  );

  // The shared ripple-carry adder, as a plain combinational sum.
  assign {add_cout, add_s} = add_x + add_y + add_cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  bit m_held;
  int m_ptr, m_id, m_sum;
  bit m_cout;

  function automatic void model_grant(output bit found, output int g);
    bit can;
    found = 0;
    g     = 0;
    can   = rst_n && (!m_held || rsp_ready);
    if (!can) return;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1;
        g     = idx;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit f;
    int g, s;
    if (!rst_n) begin
      m_held = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_cout = 0;
    end else begin
      model_grant(f, g);
      if (f) begin
        s      = int'(req_x[g*W +: W]) + int'(req_y[g*W +: W]) + int'(req_cin[g]);
        m_sum  = s % (1 << W);
        m_cout = ((s >> W) & 1) != 0;
        m_id   = g;
        m_held = 1;
        m_ptr  = (g + 1) % NREQ;
      end else if (m_held && rsp_ready) begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit f;
    int g;
    logic [NREQ-1:0] er;
    int ex, ey, ec;
    model_grant(f, g);
    er = '0; ex = 0; ey = 0; ec = 0;
    if (f) begin
      er[g] = 1'b1;
      ex    = int'(req_x[g*W +: W]);
      ey    = int'(req_y[g*W +: W]);
      ec    = int'(req_cin[g]);
    end
    check("req_ready", 32'(req_ready), 32'(er));
    check("add_x",     32'(add_x),     ex);
    check("add_y",     32'(add_y),     ey);
    check("add_cin",   32'(add_cin),   ec);
    check("rsp_valid", 32'(rsp_valid), 32'(m_held));
    check("rsp_id",    32'(rsp_id),    m_id);
    check("rsp_sum",   32'(rsp_sum),   m_sum);
    check("rsp_cout",  32'(rsp_cout),  32'(m_cout));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int x, input int y, input int c);
    req_x[i*W +: W] = W'(x);
    req_y[i*W +: W] = W'(y);
    req_cin[i]      = c[0];
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_op(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 1)));
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    repeat (3) tick();
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_id",    32'(rsp_id),    0);
    rst_n = 1'b1;

    // Single request from requester 2: 25 + 14 + 1 = 40.
    rsp_ready = 1'b1;
    set_op(2, 25, 14, 1);
    req_valid = 4'b0100;
    #1;
    check("single req_ready", 32'(req_ready), 32'h4);
    check("single add_x",     32'(add_x),     25);
    tick();
    req_valid = '0;
    #1;
    check("single rsp_valid", 32'(rsp_valid), 1);
    check("single rsp_id",    32'(rsp_id),    2);
    check("single rsp_sum",   32'(rsp_sum),   40);
    check("single rsp_cout",  32'(rsp_cout),  0);

    // Overflow cases.
    set_op(0, 63, 1, 1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1;
    check("ovf1 rsp_sum",  32'(rsp_sum),  1);
    check("ovf1 rsp_cout", 32'(rsp_cout), 1);
    check("ovf1 rsp_id",   32'(rsp_id),   0);
    set_op(1, 63, 63, 0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    check("ovf2 rsp_sum",  32'(rsp_sum),  62);
    check("ovf2 rsp_cout", 32'(rsp_cout), 1);
    tick();

    // Reset while a response is held.
    rand_ops();
    req_valid = 4'b1111;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(rsp_valid), 0);
    check("midreset rsp_sum",   32'(rsp_sum),   0);
    check("midreset req_ready", 32'(req_ready), 0);
    check("midreset add_x",     32'(add_x),     0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post-reset grant", 32'(req_ready), 32'h1);

    // Round robin with all requesters valid.
    for (int k = 0; k < 8; k++) begin
      tick();
      rand_ops();
      #1;
      check("rr rsp_valid", 32'(rsp_valid), 1);
      check("rr rsp_id",    32'(rsp_id),    k % NREQ);
    end

    // Backpressure: held id 3, pointer at 0.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp req_ready", 32'(req_ready), 0);
      check("bp rsp_id",    32'(rsp_id),    3);
      check("bp rsp_valid", 32'(rsp_valid), 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release grant", 32'(req_ready), 32'h1);
    tick();

    // Sparse: accept requester 1 to move the pointer to 2, then 1 and 3.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("sparse grant", 32'(req_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
      tick();
      check("sparse rsp_id", 32'(rsp_id), (k % 2 == 0) ? 3 : 1);
    end
    req_valid = '0;
    #1;
    check("idle add_x",   32'(add_x),   0);
    check("idle add_y",   32'(add_y),   0);
    check("idle add_cin", 32'(add_cin), 0);
    tick();
    check("idle rsp_valid", 32'(rsp_valid), 0);

    // Randomized traffic with one asynchronous reset pulse.
    for (int i = 0; i < 400; i++) begin
      tick();
      req_valid = NREQ'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
    end
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
